// File: rtl/test_run_sequencer.sv
// rtl/test_run_sequencer.sv - runs a suite of core test programs and collects their scores
//
// For each program image the core is held in reset, released, and its data
// write port is watched for the completion store to DONE_ADDR. The stored
// data is the score. A program that makes no completion store within TIMEOUT
// cycles is recorded as a timeout with a score of 0.
//
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   start              - single-cycle request to run the full suite
//   MemWrite, DataAdr,
//   WriteData          - core data-memory write port (observed only)
//   cpu_reset          - reset to the core, low only while a program runs
//   prog_sel           - instruction-memory image select
//   busy, done         - suite in progress / suite complete
//   score_valid        - one-cycle pulse per finished program
//   score_idx, score,
//   timed_out          - result of the program reported by score_valid
//   total_score        - running sum of scores (wraps)
//   timeout_mask       - bit i set when program i timed out
module test_run_sequencer #(
    parameter int NUM_TESTS    = 4,
    parameter int TIMEOUT      = 160,
    parameter int DONE_ADDR    = 252,
    parameter int RESET_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         MemWrite,
    input  logic [31:0]                  DataAdr,
    input  logic [31:0]                  WriteData,
    output logic                         cpu_reset,
    output logic [$clog2(NUM_TESTS)-1:0] prog_sel,
    output logic                         busy,
    output logic                         done,
    output logic                         score_valid,
    output logic [$clog2(NUM_TESTS)-1:0] score_idx,
    output logic [31:0]                  score,
    output logic                         timed_out,
    output logic [31:0]                  total_score,
    output logic [NUM_TESTS-1:0]         timeout_mask
);

    localparam int IW = $clog2(NUM_TESTS);
    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0] LAST_PROG = IW'(NUM_TESTS - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(TIMEOUT - 1);
    localparam logic [31:0]   DONE_A    = 32'(DONE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_RECORD,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [HW-1:0]  hcnt;
    logic [CW-1:0]  cyc;
    logic           hit;
    logic           expire;

    // Only a real store to the score address counts as completion.
    assign hit    = MemWrite && (DataAdr == DONE_A);
    assign expire = (cyc == CYC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_HOLD;
            S_HOLD:   if (hcnt == HCNT_LAST) state_next = S_RUN;
            S_RUN:    if (hit || expire) state_next = S_RECORD;
            S_RECORD: state_next = (prog_sel == LAST_PROG) ? S_DONE : S_HOLD;
            S_DONE:   if (start) state_next = S_HOLD;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_reset = (state != S_RUN);
        busy      = (state == S_HOLD) || (state == S_RUN) || (state == S_RECORD);
        done      = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prog_sel     <= '0;
            score_valid  <= 1'b0;
            score_idx    <= '0;
            score        <= '0;
            timed_out    <= 1'b0;
            total_score  <= '0;
            timeout_mask <= '0;
            hcnt         <= '0;
            cyc          <= '0;
        end else begin
            score_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        prog_sel     <= '0;
                        total_score  <= '0;
                        timeout_mask <= '0;
                        hcnt         <= '0;
                    end
                end
                S_HOLD: begin
                    if (hcnt == HCNT_LAST) begin
                        cyc <= '0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                S_RUN: begin
                    cyc <= cyc + 1'b1;
                    // Completion is checked first so a store on the final
                    // allowed cycle still reports its real score.
                    if (hit) begin
                        score       <= WriteData;
                        timed_out   <= 1'b0;
                        score_valid <= 1'b1;
                        score_idx   <= prog_sel;
                    end else if (expire) begin
                        score       <= '0;
                        timed_out   <= 1'b1;
                        score_valid <= 1'b1;
                        score_idx   <= prog_sel;
                    end
                end
                S_RECORD: begin
                    total_score            <= total_score + score;
                    timeout_mask[prog_sel] <= timeout_mask[prog_sel] | timed_out;
                    if (prog_sel != LAST_PROG) begin
                        prog_sel <= prog_sel + 1'b1;
                        hcnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_test_run_sequencer.sv
// tb/tb_test_run_sequencer.sv - directed self-checking bench for test_run_sequencer
module tb_test_run_sequencer;

    localparam int NUM_TESTS    = 4;
    localparam int TIMEOUT      = 160;
    localparam int RESET_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        cpu_reset;
    logic [1:0]  prog_sel;
    logic        busy;
    logic        done;
    logic        score_valid;
    logic [1:0]  score_idx;
    logic [31:0] score;
    logic        timed_out;
    logic [31:0] total_score;
    logic [3:0]  timeout_mask;

    int vectors     = 0;
    int miscompares = 0;

    // Per-program stub-core behaviour: RUN cycle of the completion store
    // (0 = never stores), stored data, and whether decoy writes are made.
    int          s_hit[4];
    logic [31:0] s_data[4];
    bit          s_noise[4];

    always #5 clk = ~clk;

    test_run_sequencer #(
        .NUM_TESTS(NUM_TESTS),
        .TIMEOUT(TIMEOUT),
        .DONE_ADDR(252),
        .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .MemWrite(MemWrite),
        .DataAdr(DataAdr),
        .WriteData(WriteData),
        .cpu_reset(cpu_reset),
        .prog_sel(prog_sel),
        .busy(busy),
        .done(done),
        .score_valid(score_valid),
        .score_idx(score_idx),
        .score(score),
        .timed_out(timed_out),
        .total_score(total_score),
        .timeout_mask(timeout_mask)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at a negedge in HOLD; returns at the RECORD-cycle negedge.
    task automatic run_program(input int idx, input bit inj_start);
        int          holds;
        int          k;
        bit          ended;
        int          exp_len;
        logic [31:0] exp_score;
        logic        exp_to;
        holds = 0;
        for (int n = 0; n < 20 && cpu_reset; n++) begin
            holds++;
            @(negedge clk);
        end
        check("hold_len", holds, RESET_CYCLES);
        check("run_sel", prog_sel, idx);
        exp_len   = (s_hit[idx] == 0) ? TIMEOUT : s_hit[idx];
        exp_to    = (s_hit[idx] == 0);
        exp_score = (s_hit[idx] == 0) ? 32'h0 : s_data[idx];
        k = 1;
        ended = 1'b0;
        while (!ended && k <= TIMEOUT + 5) begin
            if (k == s_hit[idx]) begin
                MemWrite = 1'b1; DataAdr = 32'd252; WriteData = s_data[idx];
            end else if (s_noise[idx] && k == 2) begin
                MemWrite = 1'b1; DataAdr = 32'd248; WriteData = 32'd77;
            end else if (s_noise[idx] && k == 3) begin
                MemWrite = 1'b1; DataAdr = 32'd256; WriteData = 32'd78;
            end else if (s_noise[idx] && k == 4) begin
                MemWrite = 1'b0; DataAdr = 32'd252; WriteData = 32'd99;
            end
            if (inj_start && k == 3) start = 1'b1;
            @(negedge clk);
            MemWrite = 1'b0; DataAdr = '0; WriteData = '0; start = 1'b0;
            if (cpu_reset) ended = 1'b1;
            else k++;
        end
        check("run_len", k, exp_len);
        check("rec_valid", score_valid, 1'b1);
        check("rec_idx", score_idx, idx);
        check("rec_score", score, exp_score);
        check("rec_timeout", timed_out, exp_to);
        check("rec_busy", busy, 1'b1);
    endtask

    task automatic run_suite(input logic [31:0] exp_total, input logic [3:0] exp_mask,
                             input bit inj_start);
        pulse_start();
        check("start_sel", prog_sel, 0);
        check("start_total", total_score, 0);
        check("start_mask", timeout_mask, 0);
        check("start_busy", busy, 1'b1);
        check("start_done", done, 1'b0);
        for (int i = 0; i < NUM_TESTS; i++) begin
            run_program(i, inj_start && i == 1);
            if (i < NUM_TESTS - 1) @(negedge clk);
        end
        check("last_rec_done", done, 1'b0);
        @(negedge clk);
        check("done", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_valid", score_valid, 1'b0);
        check("done_cpu_reset", cpu_reset, 1'b1);
        check("total", total_score, exp_total);
        check("mask", timeout_mask, exp_mask);
        repeat (5) @(negedge clk);
        check("done_hold_total", total_score, exp_total);
        check("done_hold_mask", timeout_mask, exp_mask);
        check("done_hold", done, 1'b1);
    endtask

    task automatic set_all(input int hk, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            s_hit[i] = hk; s_data[i] = d; s_noise[i] = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_sel", prog_sel, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", score_valid, 1'b0);
        check("rst_idx", score_idx, 0);
        check("rst_score", score, 0);
        check("rst_timeout", timed_out, 1'b0);
        check("rst_total", total_score, 0);
        check("rst_mask", timeout_mask, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_cpu_reset", cpu_reset, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);

        // Full pass, with a start pulse during program 1 that must be ignored.
        set_all(10, 32'd9);
        run_suite(32'd36, 4'b0000, 1'b1);

        // Program 2 never stores; restart from DONE.
        set_all(10, 32'd9);
        s_hit[2] = 0;
        run_suite(32'd27, 4'b0100, 1'b0);

        // Tie on the last allowed cycle, decoy writes, and total wrap:
        // 0xFFFFFFFF + 2 + 5 + 0xFFFFFFFB = 1 mod 2^32.
        set_all(10, 32'd0);
        s_hit[0] = TIMEOUT; s_data[0] = 32'hFFFF_FFFF;
        s_hit[1] = 7;       s_data[1] = 32'd2;
        s_hit[2] = 6;       s_data[2] = 32'd5;  s_noise[2] = 1'b1;
        s_hit[3] = 12;      s_data[3] = 32'hFFFF_FFFB;
        run_suite(32'd1, 4'b0000, 1'b0);

        // Reset in the middle of program 1.
        set_all(10, 32'd9);
        pulse_start();
        run_program(0, 1'b0);
        @(negedge clk);
        for (int n = 0; n < 20 && cpu_reset; n++) @(negedge clk);
        check("mid_run_entered", cpu_reset, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mr_cpu_reset", cpu_reset, 1'b1);
        check("mr_busy", busy, 1'b0);
        check("mr_done", done, 1'b0);
        check("mr_sel", prog_sel, 0);
        check("mr_total", total_score, 0);
        check("mr_score", score, 0);
        repeat (5) @(negedge clk);
        check("mr_stays_idle", busy, 1'b0);
        check("mr_stays_reset", cpu_reset, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
